// File: rtl/pool2x2_engine.sv
// 2x2 max/average pooling engine: reads even/odd row pairs from a dual-port
// feature-map BRAM, pools each 2x2 window and writes one packed row per pair.
module pool2x2_engine #(
    parameter int DW      = 16,
    parameter int IN_COLS = 20,
    parameter int IN_ROWS = 32,
    parameter int RAW     = 7,
    parameter int WAW     = 5,
    parameter int RD_LAT  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        mode,
    output logic                        rd_ena,
    output logic                        rd_enb,
    output logic [RAW-1:0]              rd_addra,
    output logic [RAW-1:0]              rd_addrb,
    input  logic [IN_COLS*DW-1:0]       rd_douta,
    input  logic [IN_COLS*DW-1:0]       rd_doutb,
    output logic                        wr_en,
    output logic [WAW-1:0]              wr_addr,
    output logic [(IN_COLS/2)*DW-1:0]   wr_din,
    output logic                        busy,
    output logic                        done
);

    localparam int             OCOLS      = IN_COLS / 2;
    localparam logic [RAW-1:0] LAST_ADDRA = RAW'(IN_ROWS - 2);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t                r_state, w_next;
    logic                  r_start_d;
    logic                  w_start_p;
    logic                  r_mode;
    logic                  r_ena;
    logic [RAW-1:0]        r_addra, r_addrb;
    logic [RD_LAT-1:0]     r_vld;
    logic                  w_sample;
    logic                  r_wr_en;
    logic [WAW-1:0]        r_wr_addr, r_wr_ptr;
    logic [OCOLS*DW-1:0]   r_wr_din, w_pool;

    assign w_start_p = start & ~r_start_d;
    assign w_sample  = r_vld[RD_LAT-1];

    function automatic logic [DW-1:0] pool4(
        input logic signed [DW-1:0] a0, a1, b0, b1,
        input logic                 avg
    );
        logic signed [DW-1:0] m_a, m_b;
        logic signed [DW+1:0] sum;
        m_a = (a0 > a1) ? a0 : a1;
        m_b = (b0 > b1) ? b0 : b1;
        sum = (DW+2)'(a0) + (DW+2)'(a1) + (DW+2)'(b0) + (DW+2)'(b1);
        if (avg) pool4 = DW'(sum >>> 2);
        else     pool4 = (m_a > m_b) ? m_a : m_b;
    endfunction

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // NOTE: defaults first so no path through the case leaves w_next unassigned (no latch).
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start_p) w_next = S_READ;
            S_READ:  if (r_addra == LAST_ADDRA) w_next = S_DRAIN;
            S_DRAIN: if (r_wr_en && (r_vld == '0)) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_start_d <= 1'b0;
            r_mode    <= 1'b0;
            r_ena     <= 1'b0;
            r_addra   <= '0;
            r_addrb   <= '0;
            r_vld     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_ptr  <= '0;
            r_wr_din  <= '0;
        end else begin
            r_start_d <= start;
            r_vld     <= (r_vld << 1) | RD_LAT'(r_ena);
            case (r_state)
                S_IDLE: begin
                    if (w_start_p) begin
                        r_mode   <= mode;
                        r_ena    <= 1'b1;
                        r_addra  <= '0;
                        r_addrb  <= RAW'(1);
                        r_wr_ptr <= '0;
                    end
                end
                S_READ: begin
                    if (r_addra == LAST_ADDRA) begin
                        r_ena <= 1'b0;
                    end else begin
                        r_addra <= r_addra + RAW'(2);
                        r_addrb <= r_addrb + RAW'(2);
                    end
                end
                default: ;
            endcase
            // Data arriving at the end of the valid pipeline is pooled into the write register.
            r_wr_en <= w_sample;
            if (w_sample) begin
                r_wr_din  <= w_pool;
                r_wr_addr <= r_wr_ptr;
                r_wr_ptr  <= r_wr_ptr + WAW'(1);
            end
        end
    end

    always_comb begin
        w_pool = '0;
        for (int j = 0; j < OCOLS; j++) begin
            w_pool[j*DW +: DW] = pool4(rd_douta[(2*j)*DW +: DW], rd_douta[(2*j+1)*DW +: DW],
                                       rd_doutb[(2*j)*DW +: DW], rd_doutb[(2*j+1)*DW +: DW],
                                       r_mode);
        end
    end

    assign rd_ena   = r_ena;
    assign rd_enb   = r_ena;
    assign rd_addra = r_addra;
    assign rd_addrb = r_addrb;
    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_din   = r_wr_din;
    assign busy     = (r_state == S_READ) || (r_state == S_DRAIN);
    assign done     = (r_state == S_DONE);

endmodule

// File: tb/tb_pool2x2_engine.sv
// Scoreboard bench for pool2x2_engine: default instance plus a small
// RD_LAT=1 instance, each backed by a behavioural dual-port read BRAM.
module tb_pool2x2_engine;

    localparam int DW = 16;
    localparam int C0 = 20;
    localparam int R0 = 32;
    localparam int W0 = (C0 / 2) * DW;
    localparam int C1 = 8;
    localparam int R1 = 4;
    localparam int W1 = (C1 / 2) * DW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Default-parameter instance
    logic                 d0_start, d0_mode, d0_rd_ena, d0_rd_enb, d0_wr_en, d0_busy, d0_done;
    logic [6:0]           d0_rd_addra, d0_rd_addrb;
    logic [C0*DW-1:0]     d0_rd_douta, d0_rd_doutb;
    logic [4:0]           d0_wr_addr;
    logic [W0-1:0]        d0_wr_din;

    pool2x2_engine u_dut0 (
        .clk(clk), .rst(rst), .start(d0_start), .mode(d0_mode),
        .rd_ena(d0_rd_ena), .rd_enb(d0_rd_enb), .rd_addra(d0_rd_addra), .rd_addrb(d0_rd_addrb),
        .rd_douta(d0_rd_douta), .rd_doutb(d0_rd_doutb),
        .wr_en(d0_wr_en), .wr_addr(d0_wr_addr), .wr_din(d0_wr_din),
        .busy(d0_busy), .done(d0_done)
    );

    // Small instance: RD_LAT=1, 8 columns, 4 rows
    logic                 d1_start, d1_mode, d1_rd_ena, d1_rd_enb, d1_wr_en, d1_busy, d1_done;
    logic [1:0]           d1_rd_addra, d1_rd_addrb;
    logic [C1*DW-1:0]     d1_rd_douta, d1_rd_doutb;
    logic [0:0]           d1_wr_addr;
    logic [W1-1:0]        d1_wr_din;

    pool2x2_engine #(.DW(DW), .IN_COLS(C1), .IN_ROWS(R1), .RAW(2), .WAW(1), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(d1_start), .mode(d1_mode),
        .rd_ena(d1_rd_ena), .rd_enb(d1_rd_enb), .rd_addra(d1_rd_addra), .rd_addrb(d1_rd_addrb),
        .rd_douta(d1_rd_douta), .rd_doutb(d1_rd_doutb),
        .wr_en(d1_wr_en), .wr_addr(d1_wr_addr), .wr_din(d1_wr_din),
        .busy(d1_busy), .done(d1_done)
    );

    // Behavioural BRAMs: two-cycle read for instance 0, one-cycle for instance 1
    logic [C0*DW-1:0] mem0 [R0];
    logic [C0*DW-1:0] a0_s1, b0_s1, a0_s2, b0_s2;
    always @(posedge clk) begin
        if (d0_rd_ena) begin
            a0_s1 <= mem0[d0_rd_addra[4:0]];
            b0_s1 <= mem0[d0_rd_addrb[4:0]];
        end
        a0_s2 <= a0_s1;
        b0_s2 <= b0_s1;
    end
    assign d0_rd_douta = a0_s2;
    assign d0_rd_doutb = b0_s2;

    logic [C1*DW-1:0] mem1 [R1];
    logic [C1*DW-1:0] a1_s1, b1_s1;
    always @(posedge clk) begin
        if (d1_rd_ena) begin
            a1_s1 <= mem1[d1_rd_addra];
            b1_s1 <= mem1[d1_rd_addrb];
        end
    end
    assign d1_rd_douta = a1_s1;
    assign d1_rd_doutb = b1_s1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_w(input string name, input logic [W0-1:0] act, input logic [W0-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboards
    logic [4:0]    exp0_addr [$];
    logic [W0-1:0] exp0_data [$];
    logic [0:0]    exp1_addr [$];
    logic [W1-1:0] exp1_data [$];

    int rd0_cnt, wr0_cnt, done0_cnt, first_rd0, first_wr0, last_rd0, last_wr0, done0_cyc, gap0;
    int rd1_cnt, wr1_cnt, done1_cnt, first_rd1, first_wr1;

    task automatic clear0();
        rd0_cnt = 0; wr0_cnt = 0; done0_cnt = 0; gap0 = 0;
        first_rd0 = -1; first_wr0 = -1; last_rd0 = -1; last_wr0 = -1; done0_cyc = -1;
    endtask

    logic [4:0]    ea0;
    logic [W0-1:0] ed0;
    initial begin : mon0
        forever begin
            @(negedge clk);
            if (d0_rd_ena) begin
                check("d0_rd_enb", 32'(d0_rd_enb), 32'd1);
                check("d0_rd_addra", 32'(d0_rd_addra), 2 * rd0_cnt);
                check("d0_rd_addrb", 32'(d0_rd_addrb), 2 * rd0_cnt + 1);
                check("d0_busy_rd", 32'(d0_busy), 32'd1);
                if (first_rd0 < 0) first_rd0 = cyc;
                else if (cyc != last_rd0 + 1) gap0++;
                last_rd0 = cyc;
                rd0_cnt++;
            end
            if (d0_wr_en) begin
                if (first_wr0 < 0) first_wr0 = cyc;
                last_wr0 = cyc;
                wr0_cnt++;
                check("d0_wr_expected", 32'(exp0_addr.size() != 0), 32'd1);
                if (exp0_addr.size() != 0) begin
                    ea0 = exp0_addr.pop_front();
                    ed0 = exp0_data.pop_front();
                    check("d0_wr_addr", 32'(d0_wr_addr), 32'(ea0));
                    check_w("d0_wr_din", d0_wr_din, ed0);
                end
            end
            if (d0_done) begin
                done0_cnt++;
                done0_cyc = cyc;
                check("d0_busy_at_done", 32'(d0_busy), 32'd0);
            end
        end
    end

    logic [0:0]    ea1;
    logic [W1-1:0] ed1;
    initial begin : mon1
        forever begin
            @(negedge clk);
            if (d1_rd_ena) begin
                if (first_rd1 < 0) first_rd1 = cyc;
                rd1_cnt++;
            end
            if (d1_wr_en) begin
                if (first_wr1 < 0) first_wr1 = cyc;
                wr1_cnt++;
                check("d1_wr_expected", 32'(exp1_addr.size() != 0), 32'd1);
                if (exp1_addr.size() != 0) begin
                    ea1 = exp1_addr.pop_front();
                    ed1 = exp1_data.pop_front();
                    check("d1_wr_addr", 32'(d1_wr_addr), 32'(ea1));
                    check_w("d1_wr_din", {96'b0, d1_wr_din}, {96'b0, ed1});
                end
            end
            if (d1_done) done1_cnt++;
        end
    end

    // Row r element i = r*100+i
    task automatic fill_plain0();
        for (int r = 0; r < R0; r++)
            for (int i = 0; i < C0; i++)
                mem0[r][i*DW +: DW] = 16'(r * 100 + i);
    endtask

    // Hand formulas for plain fill: max = (2k+1)*100+2j+1, avg = floor((800k+8j+202)/4)
    function automatic logic [W0-1:0] plain0(input int k, input bit avg);
        logic [W0-1:0] w;
        for (int j = 0; j < C0 / 2; j++)
            w[j*DW +: DW] = avg ? 16'(200 * k + 2 * j + 50) : 16'(200 * k + 100 + 2 * j + 1);
        return w;
    endfunction

    task automatic push0(input int k, input logic [W0-1:0] w);
        exp0_addr.push_back(5'(k));
        exp0_data.push_back(w);
    endtask

    task automatic run0(input logic m, input bit hold, input bit toggle);
        clear0();
        @(posedge clk); #1;
        d0_mode  = m;
        d0_start = 1'b1;
        @(posedge clk); #1;
        if (toggle) begin
            for (int i = 0; i < 6; i++) begin
                d0_start = ~d0_start;
                d0_mode  = ~d0_mode;
                @(posedge clk); #1;
            end
            d0_start = 1'b0;
            d0_mode  = ~m;
        end else if (!hold) begin
            d0_start = 1'b0;
        end
        for (int i = 0; i < 200; i++) begin
            if (done0_cnt != 0) break;
            @(posedge clk);
        end
        check("d0_done_seen", 32'(done0_cnt != 0), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        check("d0_rd_count", rd0_cnt, 32'd16);
        check("d0_rd_gaps", gap0, 32'd0);
        check("d0_latency", first_wr0 - first_rd0, 32'd3);
        check("d0_wr_count", wr0_cnt, 32'd16);
        check("d0_done_count", done0_cnt, 32'd1);
        check("d0_done_after_last_wr", done0_cyc - last_wr0, 32'd1);
        check("d0_queue_empty", 32'(exp0_addr.size()), 32'd0);
        check("d0_busy_idle", 32'(d0_busy), 32'd0);
    endtask

    logic [W0-1:0] w_tmp;

    initial begin : stim
        rst = 1'b1;
        d0_start = 1'b0; d0_mode = 1'b0;
        d1_start = 1'b0; d1_mode = 1'b0;
        rd1_cnt = 0; wr1_cnt = 0; done1_cnt = 0; first_rd1 = -1; first_wr1 = -1;
        clear0();
        fill_plain0();
        for (int r = 0; r < R1; r++)
            for (int i = 0; i < C1; i++)
                mem1[r][i*DW +: DW] = 16'(r * 100 + i);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_rd_ena", 32'(d0_rd_ena), 32'd0);
        check("rst_rd_enb", 32'(d0_rd_enb), 32'd0);
        check("rst_rd_addra", 32'(d0_rd_addra), 32'd0);
        check("rst_rd_addrb", 32'(d0_rd_addrb), 32'd0);
        check("rst_wr_en", 32'(d0_wr_en), 32'd0);
        check("rst_wr_addr", 32'(d0_wr_addr), 32'd0);
        check_w("rst_wr_din", d0_wr_din, '0);
        check("rst_busy", 32'(d0_busy), 32'd0);
        check("rst_done", 32'(d0_done), 32'd0);
        check("rst_d1_busy", 32'(d1_busy), 32'd0);

        // Run A: max mode, plain fill
        for (int k = 0; k < 16; k++) push0(k, plain0(k, 1'b0));
        run0(1'b0, 1'b0, 1'b0);

        // Run B: average mode with directed windows in row pair 0, start/mode toggled while busy
        fill_plain0();
        mem0[0][0*DW +: DW] = 16'd4;      mem0[1][0*DW +: DW] = 16'd6;
        mem0[0][1*DW +: DW] = 16'd5;      mem0[1][1*DW +: DW] = 16'd7;
        mem0[0][2*DW +: DW] = 16'hFFFF;   mem0[1][2*DW +: DW] = 16'hFFFF;
        mem0[0][3*DW +: DW] = 16'hFFFF;   mem0[1][3*DW +: DW] = 16'hFFFE;
        mem0[0][4*DW +: DW] = 16'h7FFF;   mem0[1][4*DW +: DW] = 16'h7FFF;
        mem0[0][5*DW +: DW] = 16'h7FFF;   mem0[1][5*DW +: DW] = 16'h7FFF;
        w_tmp = plain0(0, 1'b1);
        w_tmp[0*DW +: DW] = 16'd5;
        w_tmp[1*DW +: DW] = 16'hFFFE;
        w_tmp[2*DW +: DW] = 16'h7FFF;
        push0(0, w_tmp);
        for (int k = 1; k < 16; k++) push0(k, plain0(k, 1'b1));
        run0(1'b1, 1'b0, 1'b1);

        // Run C: signed max windows, start held high past done
        fill_plain0();
        mem0[0][0*DW +: DW] = 16'hFFFB;   mem0[1][0*DW +: DW] = 16'hFFF8;
        mem0[0][1*DW +: DW] = 16'hFFFD;   mem0[1][1*DW +: DW] = 16'h8000;
        mem0[0][2*DW +: DW] = 16'h8000;   mem0[1][2*DW +: DW] = 16'hFFFF;
        mem0[0][3*DW +: DW] = 16'h0001;   mem0[1][3*DW +: DW] = 16'h0000;
        w_tmp = plain0(0, 1'b0);
        w_tmp[0*DW +: DW] = 16'hFFFD;
        w_tmp[1*DW +: DW] = 16'h0001;
        push0(0, w_tmp);
        for (int k = 1; k < 16; k++) push0(k, plain0(k, 1'b0));
        run0(1'b0, 1'b1, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        check("hold_no_rerun_rd", rd0_cnt, 32'd16);
        check("hold_no_rerun_done", done0_cnt, 32'd1);
        check("hold_busy", 32'(d0_busy), 32'd0);
        d0_start = 1'b0;

        // Run D: reset in the fifth READ cycle; only writes for rows 0/1 precede it
        fill_plain0();
        clear0();
        push0(0, plain0(0, 1'b0));
        push0(1, plain0(1, 1'b0));
        @(posedge clk); #1;
        d0_mode  = 1'b0;
        d0_start = 1'b1;
        @(posedge clk); #1;
        d0_start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("midrst_busy_before", 32'(d0_busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_rd_ena", 32'(d0_rd_ena), 32'd0);
        check("midrst_rd_enb", 32'(d0_rd_enb), 32'd0);
        check("midrst_rd_addra", 32'(d0_rd_addra), 32'd0);
        check("midrst_rd_addrb", 32'(d0_rd_addrb), 32'd0);
        check("midrst_wr_en", 32'(d0_wr_en), 32'd0);
        check("midrst_wr_addr", 32'(d0_wr_addr), 32'd0);
        check_w("midrst_wr_din", d0_wr_din, '0);
        check("midrst_busy", 32'(d0_busy), 32'd0);
        check("midrst_done", 32'(d0_done), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        check("midrst_rd_count", rd0_cnt, 32'd5);
        check("midrst_wr_count", wr0_cnt, 32'd2);
        check("midrst_queue_empty", 32'(exp0_addr.size()), 32'd0);
        check("midrst_no_done", done0_cnt, 32'd0);

        // Run E: full run after the mid-operation reset
        for (int k = 0; k < 16; k++) push0(k, plain0(k, 1'b0));
        run0(1'b0, 1'b0, 1'b0);

        // Run F: small instance, max mode: row k -> (2k+1)*100+2j+1
        exp1_addr.push_back(1'b0);
        exp1_data.push_back({16'd107, 16'd105, 16'd103, 16'd101});
        exp1_addr.push_back(1'b1);
        exp1_data.push_back({16'd307, 16'd305, 16'd303, 16'd301});
        @(posedge clk); #1;
        d1_mode  = 1'b0;
        d1_start = 1'b1;
        @(posedge clk); #1;
        d1_start = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (done1_cnt != 0) break;
            @(posedge clk);
        end
        check("d1_done_seen", 32'(done1_cnt != 0), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        check("d1_rd_count", rd1_cnt, 32'd2);
        check("d1_latency", first_wr1 - first_rd1, 32'd2);
        check("d1_wr_count", wr1_cnt, 32'd2);
        check("d1_done_count", done1_cnt, 32'd1);
        check("d1_queue_empty", 32'(exp1_addr.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
